// File: rtl/register_file.sv
// Two-read, one-write register file: 2^N words of W bits, combinational reads, clocked write.
// Define REG_FILE_BYPASS_EN to forward write data to a read port addressing wreg in the same cycle.
module register_file #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         write,
    input  logic [N-1:0] wreg,
    input  logic [W-1:0] wdata,
    input  logic [N-1:0] rreg1,
    input  logic [N-1:0] rreg2,
    output logic [W-1:0] rdata1,
    output logic [W-1:0] rdata2
);

    localparam int unsigned DEPTH = 1 << N;

    logic [W-1:0]     regs_q [DEPTH];
    logic [W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] wr_sel_c;

    // One-hot write select; reset dominance is handled by the async clear below.
    always_comb begin
        wr_sel_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_sel_c[i] = write && (wreg == N'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel_c[i]) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Every entry, including index 0, is an ordinary clearable register.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs_q[g] <= '0;
            end else begin
                regs_q[g] <= regs_d[g];
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic fwd1_c;
    logic fwd2_c;

    always_comb begin
        fwd1_c = write && reset && (rreg1 == wreg);
        fwd2_c = write && reset && (rreg2 == wreg);
        rdata1 = fwd1_c ? wdata : regs_q[rreg1];
        rdata2 = fwd2_c ? wdata : regs_q[rreg2];
    end
`else
    always_comb begin
        rdata1 = regs_q[rreg1];
        rdata2 = regs_q[rreg2];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read pairs, a negedge monitor pops and compares.
module tb_register_file;

    localparam int unsigned W = 8;
    localparam int unsigned N = 5;
    localparam int unsigned DEPTH = 1 << N;

    typedef struct {
        string        name;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         write;
    logic [N-1:0] wreg;
    logic [W-1:0] wdata;
    logic [N-1:0] rreg1;
    logic [N-1:0] rreg2;
    logic [W-1:0] rdata1;
    logic [W-1:0] rdata2;

    logic         chk_valid;
    exp_t         sb_q[$];
    logic [W-1:0] model [DEPTH];
    int           n_cmp;
    int           n_err;

    register_file #(.W(W), .N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .write  (write),
        .wreg   (wreg),
        .wdata  (wdata),
        .rreg1  (rreg1),
        .rreg2  (rreg2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sample read ports mid-cycle whenever the stimulus flags a check.
    always @(negedge clk) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_err = n_err + 1;
                $display("FAIL scoreboard_empty: check flagged with no expected entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_cmp = n_cmp + 1;
                if (rdata1 !== e.e1) begin
                    n_err = n_err + 1;
                    $display("FAIL %s rdata1: got %02h expected %02h (rreg1=%0d)", e.name, rdata1, e.e1, rreg1);
                end
                n_cmp = n_cmp + 1;
                if (rdata2 !== e.e2) begin
                    n_err = n_err + 1;
                    $display("FAIL %s rdata2: got %02h expected %02h (rreg2=%0d)", e.name, rdata2, e.e2, rreg2);
                end
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Issued just after a rising edge; the write lands on the following edge.
    task automatic do_write(input logic [N-1:0] r, input logic [W-1:0] d);
        write = 1'b1;
        wreg  = r;
        wdata = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        model[r] = d;
    endtask

    task automatic read_check(input string nm, input logic [N-1:0] r1, input logic [N-1:0] r2,
                              input logic [W-1:0] e1, input logic [W-1:0] e2);
        exp_t e;
        rreg1  = r1;
        rreg2  = r2;
        e.name = nm;
        e.e1   = e1;
        e.e2   = e2;
        sb_q.push_back(e);
        chk_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic read_model(input string nm, input logic [N-1:0] r1, input logic [N-1:0] r2);
        read_check(nm, r1, r2, model[r1], model[r2]);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [N-1:0] i1;
        logic [N-1:0] i2;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] exp_same;
        logic [N-1:0] pairs_a [2];
        logic [N-1:0] pairs_b [2];

        n_cmp = 0;
        n_err = 0;
        chk_valid = 1'b0;
        reset = 1'b0;
        write = 1'b0;
        wreg  = '0;
        wdata = '0;
        rreg1 = '0;
        rreg2 = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill some entries so the reset clear has something to erase.
        for (int k = 0; k < 8; k++) do_write(N'($urandom_range(0, DEPTH - 1)), W'($urandom_range(1, 255)));
        do_write(5'd3, 8'h77);
        do_write(5'd31, 8'h99);
        pulse_reset();
        pairs_a[0] = 5'd3;  pairs_b[0] = 5'd17;
        pairs_a[1] = 5'd31; pairs_b[1] = 5'd0;
        for (int k = 0; k < 10; k++) begin
            if (k < 2) begin
                i1 = pairs_a[k];
                i2 = pairs_b[k];
            end else begin
                i1 = N'($urandom_range(0, DEPTH - 1));
                i2 = N'($urandom_range(0, DEPTH - 1));
            end
            read_check("reset_clear", i1, i2, 8'h00, 8'h00);
        end

        do_write(5'd7, 8'hA5);
        do_write(5'd20, 8'h3C);
        read_check("two_port", 5'd7, 5'd20, 8'hA5, 8'h3C);

        do_write(5'd9, 8'h11);
        do_write(5'd9, 8'hEE);
        read_check("overwrite", 5'd9, 5'd9, 8'hEE, 8'hEE);

        do_write(5'd0, 8'hFF);
        wdata = 8'h55;
        wreg  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        read_check("we_gating_r0", 5'd0, 5'd0, 8'hFF, 8'hFF);

        // Same-cycle read of the index being written: old value, or wdata when forwarding.
        do_write(5'd12, 8'h34);
        write = 1'b1;
        wreg  = 5'd12;
        wdata = 8'hC7;
`ifdef REG_FILE_BYPASS_EN
        exp_same = 8'hC7;
`else
        exp_same = 8'h34;
`endif
        read_check("same_cycle_rw", 5'd12, 5'd9, exp_same, 8'hEE);
        write = 1'b0;
        model[12] = 8'hC7;
        read_model("after_rw", 5'd12, 5'd12);

        do_write(5'd31, 8'h80);
        read_model("pre_async", 5'd31, 5'd31);
        write = 1'b1;
        wreg  = 5'd31;
        wdata = 8'h42;
        rreg1 = 5'd31;
        rreg2 = 5'd31;
        #2;
        reset = 1'b0;
        clear_model();
        for (int k = 0; k < 3; k++) read_check("async_reset", 5'd31, 5'd31, 8'h00, 8'h00);
        write = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        read_model("post_reset_all0", 5'd7, 5'd0);

        for (int it = 0; it < 1000; it++) begin
            i1 = N'($urandom_range(0, DEPTH - 1));
            i2 = N'($urandom_range(0, DEPTH - 1));
            d1 = W'($urandom_range(0, 255));
            d2 = W'($urandom_range(0, 255));
            do_write(i1, d1);
            do_write(i2, d2);
            read_check("random", i1, i2, (i1 == i2) ? d2 : d1, d2);
            if (it % 50 == 0) read_model("random_model", N'($urandom_range(0, DEPTH - 1)), N'($urandom_range(0, DEPTH - 1)));
        end

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
